// File: rtl/waterfall_frame_sched.sv
// Waterfall write-side scheduler: frame sync, decimation and framing checks.
// Optional per-bin peak hold over the decimation window: WATERFALL_PEAK_HOLD_EN.
module waterfall_frame_sched #(
   parameter int NUM_BINS = 512,
   parameter int BIN_W    = 9,
   parameter int DATA_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] spec_in,
   input  logic              spec_valid,
   input  logic              spec_last,
   input  logic              cfg_enable,
   input  logic [7:0]        cfg_decim,
   output logic [DATA_W-1:0] log_out,
   output logic              log_valid,
   output logic              log_last,
   output logic              frame_tick,
   output logic              err_frame
);

   typedef enum logic [2:0] {
      SYNC,
      BOUNDARY,
      PASS,
      SKIP,
      DRAIN
   } state_t;

   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

   state_t            state_q, state_d, cur_c;
   logic [BIN_W-1:0]  bin_q, bin_d;
   logic [7:0]        dcnt_q, dcnt_d;
   logic [7:0]        dec_q, dec_d;
   logic              en_q, en_d;
   logic              acc_c, emit_c, last_c, err_c, fend_c;

   logic [DATA_W-1:0] s1_data_q;
   logic              s1_vld_q, s1_last_q, s1_err_q;
   logic [DATA_W-1:0] out_data_c;

   logic [DATA_W-1:0] log_out_q;
   logic              log_valid_q, log_last_q, frame_tick_q, err_q;

`ifdef WATERFALL_PEAK_HOLD_EN
   logic [DATA_W-1:0] mem [NUM_BINS];
   logic [DATA_W-1:0] rd_q, pk_max_c, wdata_c;
   logic [BIN_W-1:0]  s1_bin_q, clr_cnt_q;
   logic              s1_wr_q, clr_q, wr_c;

   assign acc_c    = spec_valid && !clr_q;
   assign wr_c     = acc_c && (cur_c == PASS || cur_c == SKIP);
   assign pk_max_c = (s1_data_q > rd_q) ? s1_data_q : rd_q;
   assign wdata_c  = s1_vld_q ? '0 : pk_max_c;
   assign out_data_c = pk_max_c;
`else
   assign acc_c      = spec_valid;
   assign out_data_c = s1_data_q;
`endif

   // Next-state: boundary decision, framing checks and decimation count.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      dcnt_d  = dcnt_q;
      en_d    = en_q;
      dec_d   = dec_q;
      cur_c   = state_q;
      emit_c  = 1'b0;
      last_c  = 1'b0;
      err_c   = 1'b0;
      fend_c  = 1'b0;
      if (acc_c && state_q == BOUNDARY) begin
         en_d  = cfg_enable;
         dec_d = (cfg_decim == 8'd0) ? 8'd1 : cfg_decim;
         cur_c = (cfg_enable && dcnt_q == 8'd0) ? PASS : SKIP;
      end
      if (acc_c) begin
         case (cur_c)
            SYNC, DRAIN: begin
               if (spec_last) state_d = BOUNDARY;
            end
            PASS, SKIP: begin
               if (spec_last) begin
                  fend_c  = 1'b1;
                  err_c   = (bin_q != LAST_BIN);
                  state_d = BOUNDARY;
                  bin_d   = '0;
               end else if (bin_q == LAST_BIN) begin
                  fend_c  = 1'b1;
                  err_c   = 1'b1;
                  state_d = DRAIN;
                  bin_d   = '0;
               end else begin
                  state_d = cur_c;
                  bin_d   = bin_q + 1'b1;
               end
               emit_c = (cur_c == PASS);
               last_c = fend_c && (cur_c == PASS);
            end
            default: ;
         endcase
      end
      if (fend_c) begin
         if (!en_d || dcnt_q >= 8'(dec_d - 8'd1)) dcnt_d = 8'd0;
         else dcnt_d = dcnt_q + 8'd1;
      end
   end

   // Control state and latched configuration.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SYNC;
         bin_q   <= '0;
         dcnt_q  <= 8'd0;
         en_q    <= 1'b0;
         dec_q   <= 8'd1;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         dcnt_q  <= dcnt_d;
         en_q    <= en_d;
         dec_q   <= dec_d;
      end
   end

   // Input register stage carrying the per-bin decision.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_data_q <= '0;
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s1_err_q  <= 1'b0;
      end else begin
         s1_data_q <= spec_in;
         s1_vld_q  <= emit_c;
         s1_last_q <= last_c;
         s1_err_q  <= err_c;
      end
   end

   // Output register stage; data is zeroed outside valid slots.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         log_out_q    <= '0;
         log_valid_q  <= 1'b0;
         log_last_q   <= 1'b0;
         frame_tick_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         log_out_q    <= s1_vld_q ? out_data_c : '0;
         log_valid_q  <= s1_vld_q;
         log_last_q   <= s1_last_q;
         frame_tick_q <= s1_last_q;
         err_q        <= s1_err_q;
      end
   end

`ifdef WATERFALL_PEAK_HOLD_EN
   // Peak-hold side stage: bin address, write enable and clear sweep.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_bin_q  <= '0;
         s1_wr_q   <= 1'b0;
         clr_q     <= 1'b1;
         clr_cnt_q <= '0;
      end else begin
         s1_bin_q <= bin_q;
         s1_wr_q  <= wr_c;
         if (clr_q) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_BIN) clr_q <= 1'b0;
         end
      end
   end

   // Peak RAM: sync read with bypass of the same-cycle write.
   always_ff @(posedge clk) begin
      if (clr_q) mem[clr_cnt_q] <= '0;
      else if (s1_wr_q) mem[s1_bin_q] <= wdata_c;
      if (s1_wr_q && !clr_q && s1_bin_q == bin_q) rd_q <= wdata_c;
      else rd_q <= mem[bin_q];
   end
`endif

   assign log_out    = log_out_q;
   assign log_valid  = log_valid_q;
   assign log_last   = log_last_q;
   assign frame_tick = frame_tick_q;
   assign err_frame  = err_q;

endmodule

// File: doc/waterfall_frame_sched.md
Name: waterfall_frame_sched

Overview:
- Write-side scheduler for the spectrogram waterfall buffer.
- Takes a continuous stream of log-magnitude spectrum frames from the FFT/log stage and keeps one frame in every cfg_decim frames, so the scroll rate is independent of FFT rate.
- Enforces frame framing (exactly NUM_BINS bins, last flag on final bin), then drives the buffer's log_in/log_valid/log_last inputs.
- Single clock domain: the buffer's write clock.

Parameters:
- NUM_BINS, 512, bins per spectrum frame; power of two, >= 4.
- BIN_W, 9, bin index width; equals log2(NUM_BINS).
- DATA_W, 8, log-magnitude sample width.

Ports:
- clk  input  1  buffer write-side clock.
- rst_n  input  1  synchronous reset, active-low.
- spec_in  input  DATA_W  log-magnitude sample from upstream.
- spec_valid  input  1  spec_in valid this cycle; no backpressure, upstream never stalls.
- spec_last  input  1  marks the final bin of an upstream frame; qualified by spec_valid.
- cfg_enable  input  1  1 = emit frames, 0 = freeze the waterfall; sampled at frame boundary.
- cfg_decim  input  8  keep 1 of every cfg_decim frames; 0 treated as 1; sampled at frame boundary.
- log_out  output  DATA_W  sample to waterfall buffer log_in.
- log_valid  output  1  log_out valid.
- log_last  output  1  final bin of an emitted frame.
- frame_tick  output  1  one-cycle pulse, same cycle as log_last.
- err_frame  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (rst_n=0 at rising edge): all outputs 0; state SYNC; bin_cnt=0; decim_cnt=0; latched cfg values cleared (decim=1, enable=0).
- bin_cnt: counts accepted bins within the current upstream frame.
- Frame boundary: the cycle after an accepted spec_last, or after a forced termination.
- States:
  - SYNC: discard all bins until an accepted spec_last, then go to BOUNDARY. Avoids emitting a partial first frame after reset.
  - BOUNDARY: combinational decision on the first spec_valid of a frame.
    - Latch cfg_enable and cfg_decim (0 maps to 1).
    - If enable=1 and decim_cnt==0 -> PASS, else -> SKIP.
    - The first bin itself is processed in the chosen state in the same cycle (no bin lost).
  - PASS: forward bins.
  - SKIP: consume bins, emit nothing.
  - DRAIN: discard bins until spec_last; no output; entered only on long frames.
- decim_cnt:
  - Incremented at each frame end (PASS or SKIP).
  - Wraps to 0 when it reaches latched decim-1.
  - Held at 0 while enable=0, so re-enable emits the next full frame.
- Latency: PASS output appears exactly 2 cycles after the input (input register plus output register), in both feature configurations. log_valid is never asserted outside PASS-derived data.
- Short frame: spec_last with bin_cnt < NUM_BINS-1.
  - In PASS: that bin is emitted with log_last=1 and frame_tick=1.
  - In PASS or SKIP: err_frame pulses (aligned with that bin's output slot); bin_cnt=0; counts as a frame end.
- Long frame: bin_cnt == NUM_BINS-1 without spec_last.
  - In PASS: the bin is emitted with log_last=1 and frame_tick=1.
  - In PASS or SKIP: err_frame pulses; move to DRAIN (counts as a frame end).
  - On the next spec_last: no second error; go to BOUNDARY.
- Correct frame: spec_last exactly at bin_cnt == NUM_BINS-1.
- spec_valid=0 gaps: allowed anywhere; counters and state hold; output log_valid=0 for the corresponding slot.
- Reset mid-frame: outputs drop to 0 on the next cycle; the downstream buffer sees the frame truncated without log_last. The buffer tolerates this by its row-restart rule.
- cfg changes mid-frame have no effect until the next BOUNDARY.

Optional Feature:
- Macro: WATERFALL_PEAK_HOLD_EN.
- Defined:
  - Adds an NUM_BINS x DATA_W RAM with a synchronous 1-cycle read.
  - SKIP frames write max(ram[bin], spec_in) into the RAM.
  - PASS frames emit max(ram[bin], spec_in) and write 0 back to that entry.
  - Result: each emitted row is the per-bin peak over the decim window.
  - RAM cleared by a NUM_BINS-cycle sweep after reset; inputs are ignored (state SYNC held) during the sweep.
  - Bins lost to DRAIN are not accumulated.
  - Total latency stays 2 cycles.
- Not defined: no RAM; PASS forwards the sample as-is; SKIP frames are discarded.

Test Plan:
1. Reset, cfg_enable=1, cfg_decim=1, 3 clean 512-bin frames with gaps -> first frame swallowed by SYNC; frames 2,3 emitted bin-for-bin at 2-cycle latency; log_last/frame_tick on bin 511; err_frame never set.
2. cfg_decim=4, 9 clean frames after sync -> frames 1,5,9 emitted; 1536 log_valid pulses total.
3. cfg_decim=0 -> behaves as 1; cfg_decim changed 1->3 mid-frame -> change observed only from the next frame.
4. PASS frame with spec_last at bin 100 -> output of bin 100 has log_last=1, frame_tick=1, err_frame=1; next frame emitted normally. PASS frame of 600 bins -> log_last on bin 511, one err_frame, bins 512-599 dropped, next frame clean.
5. cfg_enable 1->0 mid-frame -> current frame completes; later frames not emitted; re-enable with decim=3 -> the first full frame after re-enable is emitted.
6. WATERFALL_PEAK_HOLD_EN, decim=3, bin 7 values 10,200,50 over three frames -> emitted bin 7 = 200; next window values 5,5,5 -> emitted 5 (RAM cleared).
